// File: rtl/maze_mem_arbiter.sv
// Two-requester arbiter for the single-bit maze cell memory: solver (A) and host (B)
// share one port with bounded bursts, round-robin tie break and per-requester read return.
module maze_mem_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       aReq,
    input  logic       aWr,
    input  logic [7:0] aAddr,
    input  logic       aWData,
    output logic       aGnt,
    output logic       aRData,
    output logic       aRValid,
    input  logic       bReq,
    input  logic       bWr,
    input  logic [7:0] bAddr,
    input  logic       bWData,
    output logic       bGnt,
    output logic       bRData,
    output logic       bRValid,
    output logic       memEn,
    output logic       memWr,
    output logic [7:0] memAddr,
    output logic       memWData,
    input  logic       memRData,
    output logic [7:0] conflictCnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_A = 2'd1;
    localparam logic [1:0] ST_GNT_B = 2'd2;
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       last_gnt_a_r;
    logic [3:0] burst_cnt_r;
    logic [3:0] burst_inc_s;
    logic       burst_full_s;
    logic       access_a_s;
    logic       access_b_s;
    logic       a_rd_pend_r;
    logic       b_rd_pend_r;
    logic [7:0] addr_hold_r;
    logic       wdata_hold_r;
    logic [7:0] conflict_cnt_r;

    assign access_a_s = (state_r == ST_GNT_A) && aReq;
    assign access_b_s = (state_r == ST_GNT_B) && bReq;

    // Saturating burst count as it will stand after the current access
    always_comb begin
        if (burst_cnt_r >= BURST_LIM) begin
            burst_inc_s = BURST_LIM;
        end else begin
            burst_inc_s = burst_cnt_r + 4'd1;
        end
        burst_full_s = (burst_inc_s == BURST_LIM);
    end

    // Next-state selection: hand over on release or on a full burst with the other side waiting
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (aReq && bReq) begin
                    state_nxt_s = last_gnt_a_r ? ST_GNT_B : ST_GNT_A;
                end else if (aReq) begin
                    state_nxt_s = ST_GNT_A;
                end else if (bReq) begin
                    state_nxt_s = ST_GNT_B;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT_A: begin
                if (!aReq || (burst_full_s && bReq)) begin
                    state_nxt_s = bReq ? ST_GNT_B : ST_IDLE;
                end else begin
                    state_nxt_s = ST_GNT_A;
                end
            end
            ST_GNT_B: begin
                if (!bReq || (burst_full_s && aReq)) begin
                    state_nxt_s = aReq ? ST_GNT_A : ST_IDLE;
                end else begin
                    state_nxt_s = ST_GNT_B;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Grant state, round-robin pointer and burst counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            last_gnt_a_r <= 1'b0;
            burst_cnt_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) && (state_nxt_s != ST_IDLE)) begin
                burst_cnt_r  <= 4'd0;
                last_gnt_a_r <= (state_nxt_s == ST_GNT_A);
            end else if (state_nxt_s == ST_IDLE) begin
                burst_cnt_r  <= 4'd0;
                last_gnt_a_r <= last_gnt_a_r;
            end else if (access_a_s || access_b_s) begin
                burst_cnt_r  <= burst_inc_s;
                last_gnt_a_r <= last_gnt_a_r;
            end else begin
                burst_cnt_r  <= burst_cnt_r;
                last_gnt_a_r <= last_gnt_a_r;
            end
        end
    end

    // Memory port mux; address and data hold their last value when no access is issued
    always_comb begin
        if (access_a_s) begin
            memEn    = 1'b1;
            memWr    = aWr;
            memAddr  = aAddr;
            memWData = aWData;
        end else if (access_b_s) begin
            memEn    = 1'b1;
            memWr    = bWr;
            memAddr  = bAddr;
            memWData = bWData;
        end else begin
            memEn    = 1'b0;
            memWr    = 1'b0;
            memAddr  = addr_hold_r;
            memWData = wdata_hold_r;
        end
    end

    // Read-return tracking, held address/data and the saturating conflict counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rd_pend_r    <= 1'b0;
            b_rd_pend_r    <= 1'b0;
            addr_hold_r    <= 8'd0;
            wdata_hold_r   <= 1'b0;
            conflict_cnt_r <= 8'd0;
        end else begin
            a_rd_pend_r  <= access_a_s && !aWr;
            b_rd_pend_r  <= access_b_s && !bWr;
            addr_hold_r  <= memAddr;
            wdata_hold_r <= memWData;
            if (aReq && bReq && (conflict_cnt_r != 8'hFF)) begin
                conflict_cnt_r <= conflict_cnt_r + 8'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign aGnt        = (state_r == ST_GNT_A);
    assign bGnt        = (state_r == ST_GNT_B);
    assign aRValid     = a_rd_pend_r;
    assign bRValid     = b_rd_pend_r;
    assign aRData      = a_rd_pend_r & memRData;
    assign bRData      = b_rd_pend_r & memRData;
    assign conflictCnt = conflict_cnt_r;

endmodule

// File: doc/maze_mem_arbiter.md
MAZE_MEM_ARBITER -- requirements
Module: maze_mem_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: max consecutive accesses per grant while the other requester waits; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 aReq  input  1  solver requests one memory access per cycle while high.
REQ-005 aWr  input  1  solver access type: 1 = write, 0 = read.
REQ-006 aAddr  input  8  solver cell address, {row[7:4], col[3:0]}.
REQ-007 aWData  input  1  solver write data (visited mark).
REQ-008 aGnt  output  1  solver owns the memory this cycle.
REQ-009 aRData  output  1  solver read data, valid when aRValid = 1.
REQ-010 aRValid  output  1  solver read data valid, one-cycle pulse.
REQ-011 bReq, bWr, bAddr[7:0], bWData  input  1/1/8/1  host loader/readout request, same meaning as the solver signals.
REQ-012 bGnt, bRData, bRValid  output  1/1/1  host grant and read return, same meaning as the solver signals.
REQ-013 memEn  output  1  memory access strobe.
REQ-014 memWr  output  1  memory write enable, qualified by memEn.
REQ-015 memAddr  output  8  memory address.
REQ-016 memWData  output  1  memory write data.
REQ-017 memRData  input  1  memory read data, valid one cycle after a read strobe.
REQ-018 conflictCnt  output  8  saturating count of cycles with aReq = bReq = 1.

Function
REQ-019 The arbiter SHALL be a registered FSM with states IDLE, GNT_A and GNT_B; aGnt = (state == GNT_A) and bGnt = (state == GNT_B).
REQ-020 IDLE: neither request high -> IDLE; one request high -> grant that requester next cycle; both high -> grant the requester not granted most recently (lastGnt pointer).
REQ-021 GNT_X with xReq = 1 SHALL issue one access that cycle: memEn = 1; memWr, memAddr and memWData driven from X; burstCnt increments.
REQ-022 GNT_X with xReq = 0 SHALL issue no access (memEn = 0) and SHALL leave GNT_X at the next edge.
REQ-023 Leaving GNT_X occurs when xReq = 0, or when burstCnt reaches BURST_MAX on this access and the other request is high; next state = GNT_other if the other request is high, else IDLE.
REQ-024 While the other request is low, X SHALL keep the grant indefinitely; burstCnt saturates at BURST_MAX.
REQ-025 Switching SHALL insert no idle cycle; burstCnt SHALL clear on every grant entry; lastGnt updates to X on entering GNT_X.
REQ-026 A read access in cycle N SHALL produce xRValid = 1 and xRData = memRData in cycle N+1, only for the requester that issued it, regardless of the grant in N+1.
REQ-027 Writes produce no xRValid.
REQ-028 In IDLE, memEn = memWr = 0; memAddr and memWData SHALL be held at their last value.
REQ-029 conflictCnt increments on every cycle with aReq = bReq = 1 and holds at 255.
REQ-030 Back-to-back accesses SHALL be sustained at one per cycle: full throughput with no bubbles.

Reset
REQ-031 rst = 0 SHALL force asynchronously: state = IDLE, lastGnt = B (solver wins the first tie), burstCnt = 0, conflictCnt = 0.
REQ-032 rst = 0 SHALL drive all outputs to 0, including memAddr.
REQ-033 A read issued in the cycle before reset SHALL NOT produce xRValid after reset releases.
REQ-034 Reset asserted mid-burst SHALL abort the burst; no further memEn until a new grant.

Verification
REQ-035 Solo solver: aReq = 1 for 3 cycles.
- Access 1: write addr 0x12, data 1.
- Access 2: read addr 0x12.
- Access 3: read addr 0x13.
- Response: aGnt one cycle after aReq; memEn high 3 consecutive cycles; aRValid one cycle after each read with aRData = 1, then 0; bGnt = 0 throughout.
REQ-036 Tie after reset: aReq = bReq = 1 in the same cycle -> A granted first. With BURST_MAX = 4: exactly 4 A accesses, then 4 B accesses, then A again; conflictCnt increments each tie cycle.
REQ-037 Early release: A holds the grant with bReq = 1; aReq drops after 2 accesses -> bGnt asserts in the next cycle with no idle cycle; the A read issued in its last access still returns aRValid.
REQ-038 Saturation: bReq = aReq = 1 for 300 cycles -> conflictCnt = 255 and holds.
REQ-039 Reset mid-burst: rst = 0 during an A read -> all outputs 0 immediately; after release, no aRValid; the first tie is granted to A.
